prga_decrypt_fsm: RTL

Reader/consumer side of the S-memory interface: once the key-scheduling permutation FSM has written the permuted 256-byte S array, this block reads it back and runs the RC4 pseudo-random generation algorithm (PRGA). It also performs the S swaps the PRGA requires, XORs each keystream byte with the ciphertext ROM, and writes plaintext to the result RAM. It sits beside the permutation FSM on the shared S-RAM port, and the top-level arbiter hands the port over after that FSM's `finish`.

---
 rtl/prga_decrypt_fsm_if.sv | 29 ++
 rtl/prga_decrypt_fsm.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/prga_decrypt_fsm_if.sv
// S-RAM, ciphertext ROM and result RAM bus for the RC4 PRGA decrypt FSM.
// master: the FSM (drives addresses, write data and enables).
// slave:  the memories/arbiter side (drives read data and start).
interface prga_decrypt_fsm_if;
    logic       start;
    logic [7:0] s_address;
    logic [7:0] s_data;
    logic       s_wren;
    logic [7:0] s_q;
    logic [7:0] rom_address;
    logic [7:0] rom_q;
    logic [7:0] d_address;
    logic [7:0] d_data;
    logic       d_wren;
    logic       finish;
    logic       fail;

    modport master (
        input  start, s_q, rom_q,
        output s_address, s_data, s_wren, rom_address,
               d_address, d_data, d_wren, finish, fail
    );

    modport slave (
        output start, s_q, rom_q,
        input  s_address, s_data, s_wren, rom_address,
               d_address, d_data, d_wren, finish, fail
    );
endinterface

// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA decrypt FSM: reads the permuted S array, swaps S[i]/S[j],
// XORs each keystream byte with the ciphertext ROM and writes plaintext.
// Optional macro PRGA_ASCII_CHECK_EN: abort on a non [a-z ] plaintext byte.
//
// state | meaning
// IDLE  | wait for start
// RD_I  | i <= i+1, read S[i+1] and ROM[k]
// WT_I  | S[i] and ROM[k] valid on the bus, captured into si/enc, j += S[i]
// LT_I  | spare cycle after the i read
// RD_J  | read S[j]
// WT_J  | S[j] valid, captured into sj
// LT_J  | spare cycle after the j read
// WR_I  | S[i] <= sj
// WR_J  | S[j] <= si
// RD_F  | read S[si+sj]
// WT_F  | keystream byte valid, captured into f
// LT_F  | spare cycle after the f read
// WR_D  | D[k] <= f ^ enc, advance k or finish
// DONE  | one-cycle finish pulse
module prga_decrypt_fsm #(
    parameter int MSG_LEN = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    prga_decrypt_fsm_if.master    bus
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_RD_I = 4'd1;
    localparam logic [3:0] S_WT_I = 4'd2;
    localparam logic [3:0] S_LT_I = 4'd3;
    localparam logic [3:0] S_RD_J = 4'd4;
    localparam logic [3:0] S_WT_J = 4'd5;
    localparam logic [3:0] S_LT_J = 4'd6;
    localparam logic [3:0] S_WR_I = 4'd7;
    localparam logic [3:0] S_WR_J = 4'd8;
    localparam logic [3:0] S_RD_F = 4'd9;
    localparam logic [3:0] S_WT_F = 4'd10;
    localparam logic [3:0] S_LT_F = 4'd11;
    localparam logic [3:0] S_WR_D = 4'd12;
    localparam logic [3:0] S_DONE = 4'd13;

    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

    logic [3:0] r_state;
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_k;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic [7:0] r_f;
    logic [7:0] r_enc;
    logic [7:0] w_plain;
    logic       w_accept;

    assign w_plain = r_f ^ r_enc;

`ifdef PRGA_ASCII_CHECK_EN
    logic r_fail;
    assign w_accept = ((w_plain >= 8'h61) && (w_plain <= 8'h7A)) || (w_plain == 8'h20);
    assign bus.fail = r_fail;
`else
    assign w_accept = 1'b1;
    assign bus.fail = 1'b0;
`endif

    // State sequencing and datapath registers. The memories have one cycle
    // of read latency and the address is only driven in RD_*, so read data
    // is captured on the edge leaving WT_*; LT_* are pure pacing cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_f     <= '0;
            r_enc   <= '0;
`ifdef PRGA_ASCII_CHECK_EN
            r_fail  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
`ifdef PRGA_ASCII_CHECK_EN
                        r_fail  <= 1'b0;
`endif
                        r_state <= S_RD_I;
                    end
                end
                S_RD_I: begin
                    r_i     <= r_i + 8'd1;
                    r_state <= S_WT_I;
                end
                S_WT_I: begin
                    r_si    <= bus.s_q;
                    r_j     <= r_j + bus.s_q;
                    r_enc   <= bus.rom_q;
                    r_state <= S_LT_I;
                end
                S_LT_I: r_state <= S_RD_J;
                S_RD_J: r_state <= S_WT_J;
                S_WT_J: begin
                    r_sj    <= bus.s_q;
                    r_state <= S_LT_J;
                end
                S_LT_J: r_state <= S_WR_I;
                S_WR_I: r_state <= S_WR_J;
                S_WR_J: r_state <= S_RD_F;
                S_RD_F: r_state <= S_WT_F;
                S_WT_F: begin
                    r_f     <= bus.s_q;
                    r_state <= S_LT_F;
                end
                S_LT_F: r_state <= S_WR_D;
                S_WR_D: begin
`ifdef PRGA_ASCII_CHECK_EN
                    if (!w_accept) begin
                        r_fail  <= 1'b1;
                        r_state <= S_DONE;
                    end else
`endif
                    if (r_k == LAST_K) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k     <= r_k + 8'd1;
                        r_state <= S_RD_I;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory-side outputs decoded from state; idle value is all zero.
    always_comb begin
        bus.s_address   = '0;
        bus.s_data      = '0;
        bus.s_wren      = 1'b0;
        bus.rom_address = '0;
        bus.d_address   = '0;
        bus.d_data      = '0;
        bus.d_wren      = 1'b0;
        bus.finish      = 1'b0;
        case (r_state)
            S_RD_I: begin
                bus.s_address   = r_i + 8'd1;
                bus.rom_address = r_k;
            end
            S_RD_J: bus.s_address = r_j;
            S_WR_I: begin
                bus.s_address = r_i;
                bus.s_data    = r_sj;
                bus.s_wren    = 1'b1;
            end
            S_WR_J: begin
                bus.s_address = r_j;
                bus.s_data    = r_si;
                bus.s_wren    = 1'b1;
            end
            S_RD_F: bus.s_address = r_si + r_sj;
            S_WR_D: begin
                bus.d_address = r_k;
                bus.d_data    = w_plain;
                bus.d_wren    = w_accept;
            end
            S_DONE:  bus.finish = 1'b1;
            default: ;
        endcase
    end
endmodule
